extended_axis_packet_merger: RTL and testbench

Downstream companion of the multi-channel AXI-Stream packet splitter. Consumes CHANNELS lock-stepped streams already cut into packets (tlast per packet) and re-merges a programmed number of packets into one output packet: intermediate tlast is stripped, tlast is asserted only on the final beat of the Nth packet. Same start/busy/complete/error control style as the splitter, so firmware drives both stages identically.

---
 rtl/extended_axis_packet_merger_pkg.sv | 19 +
 rtl/extended_axis_packet_merger_out_reg.sv | 82 ++++++++
 rtl/extended_axis_packet_merger.sv | 185 ++++++++++++++++++
 tb/tb_extended_axis_packet_merger.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/extended_axis_packet_merger_pkg.sv
// Shared types for the AXI-Stream split/merge stages.
// FSM encoding and disabled-field default helper.
package extended_axis_packet_merger_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  // Disabled sideband fields: tkeep reads all-ones, the rest read zero.
  function automatic logic field_default(input logic is_keep);
    return is_keep;
  endfunction

endpackage

// File: rtl/extended_axis_packet_merger_out_reg.sv
// One channel of the lock-stepped output register.
// Tracks whether this channel's beat has been taken downstream.
module axis_lockstep_out_reg #(
  parameter int DW  = 16,
  parameter int KW  = 2,
  parameter int IW  = 1,
  parameter int DSW = 1,
  parameter int UW  = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr_i,
  input  logic           load_i,
  input  logic           all_done_i,
  input  logic [DW-1:0]  s_data_i,
  input  logic [KW-1:0]  s_keep_i,
  input  logic           s_last_i,
  input  logic [IW-1:0]  s_id_i,
  input  logic [DSW-1:0] s_dest_i,
  input  logic [UW-1:0]  s_user_i,
  input  logic           m_tready_i,
  output logic           m_tvalid_o,
  output logic [DW-1:0]  m_data_o,
  output logic [KW-1:0]  m_keep_o,
  output logic           m_last_o,
  output logic [IW-1:0]  m_id_o,
  output logic [DSW-1:0] m_dest_o,
  output logic [UW-1:0]  m_user_o,
  output logic           done_o
);

  logic valid_q, valid_d;
  logic taken_q, taken_d;
  logic hs;

  assign m_tvalid_o = valid_q & ~taken_q;
  assign hs         = m_tvalid_o & m_tready_i;
  // Done counts this cycle's handshake so the slot frees without a bubble.
  assign done_o     = ~valid_q | taken_q | hs;

  always_comb begin
    valid_d = valid_q;
    taken_d = taken_q;
    if (clr_i) begin
      valid_d = 1'b0;
      taken_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      taken_d = 1'b0;
    end else if (all_done_i) begin
      valid_d = 1'b0;
      taken_d = 1'b0;
    end else if (hs) begin
      taken_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      taken_q  <= 1'b0;
      m_data_o <= '0;
      m_keep_o <= '0;
      m_last_o <= 1'b0;
      m_id_o   <= '0;
      m_dest_o <= '0;
      m_user_o <= '0;
    end else begin
      valid_q <= valid_d;
      taken_q <= taken_d;
      if (load_i && !clr_i) begin
        m_data_o <= s_data_i;
        m_keep_o <= s_keep_i;
        m_last_o <= s_last_i;
        m_id_o   <= s_id_i;
        m_dest_o <= s_dest_i;
        m_user_o <= s_user_i;
      end
    end
  end

endmodule

// File: rtl/extended_axis_packet_merger.sv
// Merges pckt_num lock-stepped input packets into one output packet.
// MERGER_TLAST_CHECK_EN: abort when channels disagree on tlast.
module extended_axis_packet_merger
  import extended_axis_packet_merger_pkg::*;
#(
  parameter int CHANNELS    = 1,
  parameter int DATA_WIDTH  = 16,
  parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = KEEP_ENABLE ? (DATA_WIDTH + 7) / 8 : 1,
  parameter bit ID_ENABLE   = 0,
  parameter int ID_WIDTH    = ID_ENABLE ? 8 : 1,
  parameter bit DEST_ENABLE = 0,
  parameter int DEST_WIDTH  = DEST_ENABLE ? 8 : 1,
  parameter bit USER_ENABLE = 0,
  parameter int USER_WIDTH  = USER_ENABLE ? 8 : 1,
  parameter int PCKT_WIDTH  = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             operation_start,
  input  logic [PCKT_WIDTH-1:0]            pckt_num,
  input  logic                             external_error,
  output logic                             operation_busy,
  output logic                             operation_complete,
  output logic                             operation_error,
  input  logic [CHANNELS*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [CHANNELS*KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic [CHANNELS-1:0]              s_axis_tvalid,
  output logic [CHANNELS-1:0]              s_axis_tready,
  input  logic [CHANNELS-1:0]              s_axis_tlast,
  input  logic [CHANNELS*ID_WIDTH-1:0]     s_axis_tid,
  input  logic [CHANNELS*DEST_WIDTH-1:0]   s_axis_tdest,
  input  logic [CHANNELS*USER_WIDTH-1:0]   s_axis_tuser,
  output logic [CHANNELS*DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [CHANNELS*KEEP_WIDTH-1:0]   m_axis_tkeep,
  output logic [CHANNELS-1:0]              m_axis_tvalid,
  input  logic [CHANNELS-1:0]              m_axis_tready,
  output logic [CHANNELS-1:0]              m_axis_tlast,
  output logic [CHANNELS*ID_WIDTH-1:0]     m_axis_tid,
  output logic [CHANNELS*DEST_WIDTH-1:0]   m_axis_tdest,
  output logic [CHANNELS*USER_WIDTH-1:0]   m_axis_tuser
);

  state_e                state_q, state_d;
  logic [PCKT_WIDTH-1:0] pckt_num_q, pckt_num_d;
  logic [PCKT_WIDTH-1:0] pckt_cnt_q, pckt_cnt_d;
  logic                  err_q, err_d;
  logic                  cmpl_q, cmpl_d;

  logic [CHANNELS-1:0] done;
  logic all_done, all_valid, run_take;
  logic tlast_bad, abort, load, final_beat;
  logic unused_ok;

  assign all_done   = &done;
  assign all_valid  = &s_axis_tvalid;
  assign operation_busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign run_take   = (state_q == ST_RUN) & all_valid & all_done;

`ifdef MERGER_TLAST_CHECK_EN
  assign tlast_bad  = run_take & (|s_axis_tlast) & ~(&s_axis_tlast);
`else
  assign tlast_bad  = 1'b0;
`endif

  assign abort      = (operation_busy & external_error) | tlast_bad;
  assign load       = run_take & ~abort;
  assign s_axis_tready = {CHANNELS{load}};
  assign final_beat = s_axis_tlast[0] &&
                      (pckt_cnt_q == pckt_num_q - PCKT_WIDTH'(1));

  assign operation_complete = cmpl_q;
  assign operation_error    = err_q;

  assign unused_ok = ^{s_axis_tlast, s_axis_tkeep, s_axis_tid,
                       s_axis_tdest, s_axis_tuser};

  always_comb begin
    state_d    = state_q;
    pckt_num_d = pckt_num_q;
    pckt_cnt_d = pckt_cnt_q;
    err_d      = err_q;
    cmpl_d     = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_ERROR: begin
        // A start coinciding with the completion pulse is dropped.
        if (operation_start && !cmpl_q) begin
          if (pckt_num == '0) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end else begin
            state_d    = ST_RUN;
            pckt_num_d = pckt_num;
            pckt_cnt_d = '0;
            err_d      = 1'b0;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_ERROR;
          err_d   = 1'b1;
        end else if (load && s_axis_tlast[0]) begin
          pckt_cnt_d = pckt_cnt_q + PCKT_WIDTH'(1);
          if (final_beat) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_d = ST_ERROR;
          err_d   = 1'b1;
        end else if (all_done) begin
          state_d = ST_IDLE;
          cmpl_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pckt_num_q <= '0;
      pckt_cnt_q <= '0;
      err_q      <= 1'b0;
      cmpl_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pckt_num_q <= pckt_num_d;
      pckt_cnt_q <= pckt_cnt_d;
      err_q      <= err_d;
      cmpl_q     <= cmpl_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [KEEP_WIDTH-1:0] keep_in, keep_out;
    logic [ID_WIDTH-1:0]   id_in;
    logic [DEST_WIDTH-1:0] dest_in;
    logic [USER_WIDTH-1:0] user_in;

    assign keep_in = KEEP_ENABLE ? s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH]
                                 : {KEEP_WIDTH{field_default(1'b1)}};
    assign id_in   = ID_ENABLE ? s_axis_tid[i*ID_WIDTH +: ID_WIDTH]
                               : {ID_WIDTH{field_default(1'b0)}};
    assign dest_in = DEST_ENABLE ? s_axis_tdest[i*DEST_WIDTH +: DEST_WIDTH]
                                 : {DEST_WIDTH{field_default(1'b0)}};
    assign user_in = USER_ENABLE ? s_axis_tuser[i*USER_WIDTH +: USER_WIDTH]
                                 : {USER_WIDTH{field_default(1'b0)}};

    assign m_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH] =
      KEEP_ENABLE ? keep_out : {KEEP_WIDTH{field_default(1'b1)}};

    axis_lockstep_out_reg #(
      .DW (DATA_WIDTH),
      .KW (KEEP_WIDTH),
      .IW (ID_WIDTH),
      .DSW(DEST_WIDTH),
      .UW (USER_WIDTH)
    ) u_reg (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (abort),
      .load_i    (load),
      .all_done_i(all_done),
      .s_data_i  (s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH]),
      .s_keep_i  (keep_in),
      .s_last_i  (final_beat),
      .s_id_i    (id_in),
      .s_dest_i  (dest_in),
      .s_user_i  (user_in),
      .m_tready_i(m_axis_tready[i]),
      .m_tvalid_o(m_axis_tvalid[i]),
      .m_data_o  (m_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH]),
      .m_keep_o  (keep_out),
      .m_last_o  (m_axis_tlast[i]),
      .m_id_o    (m_axis_tid[i*ID_WIDTH +: ID_WIDTH]),
      .m_dest_o  (m_axis_tdest[i*DEST_WIDTH +: DEST_WIDTH]),
      .m_user_o  (m_axis_tuser[i*USER_WIDTH +: USER_WIDTH]),
      .done_o    (done[i])
    );
  end

endmodule

// File: tb/tb_extended_axis_packet_merger.sv
// Bench for extended_axis_packet_merger, CHANNELS=2, DATA_WIDTH=16.
// Control table plus multi-beat merge sequences.
module tb_extended_axis_packet_merger;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] pnum;
  logic        ext;
  logic        busy, cmpl, err;
  logic [31:0] s_data;
  logic [3:0]  s_keep;
  logic [1:0]  s_valid, s_ready, s_last, s_id, s_dest, s_user;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic [1:0]  m_valid, m_ready, m_last, m_id, m_dest, m_user;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int cmpl_cnt = 0;
  int cmpl_cyc = 0;
  int last_hs = 0;
  logic mon_en = 1'b0;
  logic [15:0] rx0_d[$], rx1_d[$];
  logic        rx0_l[$], rx1_l[$];

  always #5 clk = ~clk;

  extended_axis_packet_merger #(
    .CHANNELS(2),
    .DATA_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .operation_start(start), .pckt_num(pnum), .external_error(ext),
    .operation_busy(busy), .operation_complete(cmpl),
    .operation_error(err),
    .s_axis_tdata(s_data), .s_axis_tkeep(s_keep),
    .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
    .s_axis_tlast(s_last), .s_axis_tid(s_id),
    .s_axis_tdest(s_dest), .s_axis_tuser(s_user),
    .m_axis_tdata(m_data), .m_axis_tkeep(m_keep),
    .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
    .m_axis_tlast(m_last), .m_axis_tid(m_id),
    .m_axis_tdest(m_dest), .m_axis_tuser(m_user)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Samples just before the rising edge: what is seen here is what the edge takes.
  always @(negedge clk) begin
    #4;
    if (mon_en) begin
      if (m_valid[0] & m_ready[0]) begin
        rx0_d.push_back(m_data[15:0]);
        rx0_l.push_back(m_last[0]);
        last_hs = cyc;
      end
      if (m_valid[1] & m_ready[1]) begin
        rx1_d.push_back(m_data[31:16]);
        rx1_l.push_back(m_last[1]);
        last_hs = cyc;
      end
      if (cmpl) begin
        cmpl_cnt++;
        cmpl_cyc = cyc;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic clear_mon();
    rx0_d.delete(); rx1_d.delete();
    rx0_l.delete(); rx1_l.delete();
    cmpl_cnt = 0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; pnum = '0; ext = 1'b0;
    s_valid = '0; s_last = '0; s_data = '0; m_ready = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_start(input logic [31:0] n);
    @(negedge clk);
    start = 1'b1; pnum = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input int n, input int plen, input logic [15:0] base,
                      input string tag);
    int b = 0;
    int guard = 0;
    while (b < n && guard < 400) begin
      @(negedge clk);
      s_valid = 2'b11;
      s_data  = {base + 16'h0080 + 16'(b), base + 16'(b)};
      s_last  = {2{(b % plen) == plen - 1}};
      #4;
      if (s_ready == 2'b11) b++;
      guard++;
    end
    @(negedge clk);
    s_valid = '0; s_last = '0;
    chk({tag, "_sent"}, b, n);
  endtask

  task automatic wait_cmpl(input string tag);
    int g = 0;
    while (cmpl_cnt == 0 && g < 100) begin
      @(posedge clk);
      g++;
    end
    repeat (4) @(posedge clk);
    chk({tag, "_cmpl_cnt"}, cmpl_cnt, 1);
    chk({tag, "_cmpl_lat"}, cmpl_cyc - last_hs, 1);
  endtask

  task automatic check_rx(input int n, input int plen, input logic [15:0] base,
                          input string tag);
    chk({tag, "_rx0_n"}, rx0_d.size(), n);
    chk({tag, "_rx1_n"}, rx1_d.size(), n);
    for (int j = 0; j < n; j++) begin
      chk($sformatf("%s_d0_%0d", tag, j), rx0_d[j], base + 16'(j));
      chk($sformatf("%s_d1_%0d", tag, j), rx1_d[j], base + 16'h0080 + 16'(j));
      chk($sformatf("%s_l0_%0d", tag, j), rx0_l[j], j == n - 1);
      chk($sformatf("%s_l1_%0d", tag, j), rx1_l[j], j == n - 1);
    end
  endtask

  typedef struct {
    logic        start;
    logic [31:0] num;
    logic        ext;
    logic [1:0]  sv, sl, mr;
    logic        srdy, busy, err, cmpl;
    logic [1:0]  mv;
    logic        mlast;
  } vec_t;

  vec_t tv[13];

  initial begin
    s_keep = 4'hF; s_id = '0; s_dest = '0; s_user = '0;
    //         st num ext sv     sl     mr     srdy bsy err cmp mv     ml
    tv[0]  = '{0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0};
    tv[1]  = '{1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 2'b00, 0};
    tv[2]  = '{0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0, 1, 0, 2'b00, 0};
    tv[3]  = '{1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0, 2'b00, 0};
    tv[4]  = '{0, 0, 0, 2'b11, 2'b00, 2'b11, 1, 1, 0, 0, 2'b11, 0};
    tv[5]  = '{0, 0, 0, 2'b11, 2'b11, 2'b11, 1, 1, 0, 0, 2'b11, 1};
    tv[6]  = '{0, 0, 0, 2'b11, 2'b00, 2'b11, 0, 0, 0, 1, 2'b00, 0};
    tv[7]  = '{1, 2, 0, 2'b00, 2'b00, 2'b11, 0, 0, 0, 0, 2'b00, 0};
    tv[8]  = '{1, 2, 0, 2'b00, 2'b00, 2'b11, 0, 1, 0, 0, 2'b00, 0};
    tv[9]  = '{0, 0, 0, 2'b11, 2'b00, 2'b11, 1, 1, 0, 0, 2'b11, 0};
    tv[10] = '{0, 0, 1, 2'b11, 2'b00, 2'b00, 0, 0, 1, 0, 2'b00, 0};
    tv[11] = '{0, 0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 2'b00, 0};
    tv[12] = '{1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0, 2'b00, 0};

    reset_dut();
    @(negedge clk);
    s_valid = 2'b11;
    #4;
    chk("rst_sready", s_ready, 2'b00);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_cmpl", cmpl, 0);
    chk("rst_mvalid", m_valid, 2'b00);

    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      start = tv[k].start; pnum = tv[k].num; ext = tv[k].ext;
      s_valid = tv[k].sv; s_last = tv[k].sl; m_ready = tv[k].mr;
      s_data = {16'hB000 + 16'(k), 16'hA000 + 16'(k)};
      #4;
      chk($sformatf("v%0d_sready", k), s_ready, {2{tv[k].srdy}});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_busy", k), busy, tv[k].busy);
      chk($sformatf("v%0d_err", k), err, tv[k].err);
      chk($sformatf("v%0d_cmpl", k), cmpl, tv[k].cmpl);
      chk($sformatf("v%0d_mvalid", k), m_valid, tv[k].mv);
      if (tv[k].mv != 2'b00)
        chk($sformatf("v%0d_mlast", k), m_last, {2{tv[k].mlast}});
    end

    // Three 4-beat packets merged into one 12-beat packet.
    reset_dut();
    clear_mon();
    mon_en = 1'b1;
    m_ready = 2'b11;
    do_start(3);
    send(12, 4, 16'h1000, "s1");
    wait_cmpl("s1");
    check_rx(12, 4, 16'h1000, "s1");

    // Channel 1 stalls five cycles mid-packet.
    reset_dut();
    clear_mon();
    m_ready = 2'b11;
    do_start(3);
    fork
      send(12, 4, 16'h2000, "s2");
      begin
        repeat (6) @(negedge clk);
        m_ready[1] = 1'b0;
        repeat (2) @(negedge clk);
        #4;
        chk("s2_stall_mvalid", m_valid, 2'b10);
        chk("s2_stall_sready", s_ready, 2'b00);
        repeat (3) @(negedge clk);
        m_ready[1] = 1'b1;
      end
    join
    wait_cmpl("s2");
    check_rx(12, 4, 16'h2000, "s2");

    // Channels disagree on tlast at the packet end.
    reset_dut();
    clear_mon();
    m_ready = 2'b11;
    do_start(1);
    send(3, 100, 16'h3000, "s3");
    @(negedge clk);
    s_valid = 2'b11; s_last = 2'b01;
    s_data = {16'h3083, 16'h3003};
    #4;
`ifdef MERGER_TLAST_CHECK_EN
    chk("s3_sready", s_ready, 2'b00);
    @(posedge clk);
    #1;
    chk("s3_busy", busy, 0);
    chk("s3_err", err, 1);
    chk("s3_mvalid", m_valid, 2'b00);
    @(negedge clk);
    s_valid = '0; s_last = '0;
    repeat (5) @(posedge clk);
    chk("s3_cmpl_cnt", cmpl_cnt, 0);
    chk("s3_rx0_n", rx0_d.size(), 3);
`else
    chk("s3_sready", s_ready, 2'b11);
    @(posedge clk);
    #1;
    chk("s3_busy", busy, 1);
    chk("s3_mvalid", m_valid, 2'b11);
    chk("s3_mlast", m_last, 2'b11);
    @(negedge clk);
    s_valid = '0; s_last = '0;
    wait_cmpl("s3");
    check_rx(4, 4, 16'h3000, "s3");
`endif

    // Reset while draining, then a fresh merge.
    reset_dut();
    clear_mon();
    m_ready = 2'b00;
    do_start(1);
    send(1, 1, 16'h4000, "s4");
    @(posedge clk);
    #1;
    chk("s4_drain_busy", busy, 1);
    chk("s4_drain_mvalid", m_valid, 2'b11);
    @(negedge clk);
    rst = 1'b1; s_valid = 2'b11;
    @(posedge clk);
    #1;
    chk("s4_rst_busy", busy, 0);
    chk("s4_rst_err", err, 0);
    chk("s4_rst_cmpl", cmpl, 0);
    chk("s4_rst_mvalid", m_valid, 2'b00);
    chk("s4_rst_sready", s_ready, 2'b00);
    @(negedge clk);
    rst = 1'b0; s_valid = '0;
    clear_mon();
    m_ready = 2'b11;
    do_start(1);
    send(2, 2, 16'h5000, "s5");
    wait_cmpl("s5");
    check_rx(2, 2, 16'h5000, "s5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
